// File: rtl/riscv_result_checker.sv
// Retirement checker for RISCV_TOP: grades NUM_INST/OUTPUT_PORT/HALT against a loaded
// table of (instruction count, answer) pairs and reports pass/fail/timeout counts.
module riscv_result_checker #(
   parameter int NUM_TEST    = 22,
   parameter int IDW         = 5,
   parameter int TIMEOUT_CYC = 100000
) (
   input  logic            CLK,
   input  logic            RSTn,
   input  logic            TBL_WE,
   input  logic [IDW-1:0]  TBL_IDX,
   input  logic [31:0]     TBL_NUM_INST,
   input  logic [31:0]     TBL_ANS,
   input  logic [IDW:0]    NUM_ENTRIES,
   input  logic            START,
   input  logic [31:0]     NUM_INST,
   input  logic [31:0]     OUTPUT_PORT,
   input  logic            HALT,
   output logic            BUSY,
   output logic            DONE,
   output logic            ALL_PASS,
   output logic [IDW:0]    PASS_CNT,
   output logic [IDW:0]    FAIL_CNT,
   output logic            FIRST_FAIL_VLD,
   output logic [IDW-1:0]  FIRST_FAIL_IDX,
   output logic            TIMEOUT,
   output logic [31:0]     CYCLE_CNT
);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   localparam logic [IDW:0] NUM_TEST_W = (IDW+1)'(NUM_TEST);
   localparam logic [31:0]  TIMEOUT_LAST = 32'(TIMEOUT_CYC - 1);

   state_t          r_state;
   logic [31:0]     r_tbl_num [NUM_TEST];
   logic [31:0]     r_tbl_ans [NUM_TEST];
   logic [IDW:0]    r_ptr;
   logic [IDW:0]    r_entries;
   logic [IDW:0]    r_pass_cnt;
   logic [IDW:0]    r_fail_cnt;
   logic            r_ff_vld;
   logic [IDW-1:0]  r_ff_idx;
   logic            r_timeout;
   logic [31:0]     r_cycle_cnt;

   logic [31:0]     w_e_num;
   logic [31:0]     w_e_ans;
   logic            w_match;
   logic            w_skip;
   logic            w_graded;
   logic            w_pass;
   logic            w_fail;
   logic [IDW:0]    w_ptr_nxt;
   logic [IDW:0]    w_pass_nxt;
   logic [IDW:0]    w_fail_nxt;
   logic [IDW:0]    w_remain;
   logic            w_last;
   logic            w_timeout_hit;
   logic [IDW:0]    w_entries_clamp;
   logic            w_start;

   // NOTE: the table is a plain register array with no reset so it maps onto RAM and
   // survives RSTn; it is only writable in IDLE so grading always sees a frozen table.
   always_ff @(posedge CLK) begin
      if (TBL_WE && r_state == S_IDLE && {1'b0, TBL_IDX} < NUM_TEST_W) begin
         r_tbl_num[TBL_IDX] <= TBL_NUM_INST;
         r_tbl_ans[TBL_IDX] <= TBL_ANS;
      end
   end

   assign w_e_num         = r_tbl_num[r_ptr[IDW-1:0]];
   assign w_e_ans         = r_tbl_ans[r_ptr[IDW-1:0]];
   assign w_match         = (NUM_INST == w_e_num);
   assign w_skip          = (NUM_INST > w_e_num);
   assign w_graded        = w_match | w_skip;
   assign w_pass          = w_match & (OUTPUT_PORT == w_e_ans);
   assign w_fail          = w_graded & ~w_pass;
   assign w_ptr_nxt       = r_ptr + (IDW+1)'(w_graded);
   assign w_pass_nxt      = r_pass_cnt + (IDW+1)'(w_pass);
   assign w_fail_nxt      = r_fail_cnt + (IDW+1)'(w_fail);
   assign w_remain        = r_entries - w_ptr_nxt;
   assign w_last          = (w_ptr_nxt == r_entries);
   assign w_timeout_hit   = (r_cycle_cnt == TIMEOUT_LAST);
   assign w_entries_clamp = (NUM_ENTRIES > NUM_TEST_W) ? NUM_TEST_W : NUM_ENTRIES;
   assign w_start         = START && (r_state != S_RUN);

   // NOTE: sequential state uses non-blocking assignments only; later assignments in the
   // same block override earlier ones, which encodes grade-then-HALT-then-timeout priority.
   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         r_state     <= S_IDLE;
         r_ptr       <= '0;
         r_entries   <= '0;
         r_pass_cnt  <= '0;
         r_fail_cnt  <= '0;
         r_ff_vld    <= 1'b0;
         r_ff_idx    <= '0;
         r_timeout   <= 1'b0;
         r_cycle_cnt <= '0;
      end else if (w_start) begin
         r_ptr       <= '0;
         r_entries   <= w_entries_clamp;
         r_pass_cnt  <= '0;
         r_fail_cnt  <= '0;
         r_ff_vld    <= 1'b0;
         r_ff_idx    <= '0;
         r_timeout   <= 1'b0;
         r_cycle_cnt <= '0;
         r_state     <= (w_entries_clamp == '0) ? S_DONE : S_RUN;
      end else if (r_state == S_RUN) begin
         if (r_cycle_cnt != '1) r_cycle_cnt <= r_cycle_cnt + 32'd1;
         r_ptr      <= w_ptr_nxt;
         r_pass_cnt <= w_pass_nxt;
         r_fail_cnt <= w_fail_nxt;
         if (w_fail && !r_ff_vld) begin
            r_ff_vld <= 1'b1;
            r_ff_idx <= r_ptr[IDW-1:0];
         end
         if (w_last) begin
            r_state <= S_DONE;
         end else if (HALT || w_timeout_hit) begin
            // Everything from the next ungraded entry onward counts as missed.
            r_fail_cnt <= w_fail_nxt + w_remain;
            if (!r_ff_vld && !w_fail) begin
               r_ff_vld <= 1'b1;
               r_ff_idx <= w_ptr_nxt[IDW-1:0];
            end
            r_timeout <= ~HALT;
            r_state   <= S_DONE;
         end
      end
   end

   assign BUSY           = (r_state == S_RUN);
   assign DONE           = (r_state == S_DONE);
   assign ALL_PASS       = DONE && (r_pass_cnt == r_entries) && !r_timeout;
   assign PASS_CNT       = r_pass_cnt;
   assign FAIL_CNT       = r_fail_cnt;
   assign FIRST_FAIL_VLD = r_ff_vld;
   assign FIRST_FAIL_IDX = r_ff_idx;
   assign TIMEOUT        = r_timeout;
   assign CYCLE_CNT      = r_cycle_cnt;

endmodule

// File: tb/tb_riscv_result_checker.sv
// Scoreboard bench for riscv_result_checker: expected grading results are queued at START
// and compared when DONE is reached.
module tb_riscv_result_checker;

   localparam int NUM_TEST = 22;
   localparam int IDW      = 5;
   localparam int TO_CYC   = 16;

   logic            CLK = 1'b0;
   logic            RSTn = 1'b0;
   logic            TBL_WE = 1'b0;
   logic [IDW-1:0]  TBL_IDX = '0;
   logic [31:0]     TBL_NUM_INST = '0;
   logic [31:0]     TBL_ANS = '0;
   logic [IDW:0]    NUM_ENTRIES = '0;
   logic            START = 1'b0;
   logic [31:0]     NUM_INST = '0;
   logic [31:0]     OUTPUT_PORT = '0;
   logic            HALT = 1'b0;
   logic            BUSY;
   logic            DONE;
   logic            ALL_PASS;
   logic [IDW:0]    PASS_CNT;
   logic [IDW:0]    FAIL_CNT;
   logic            FIRST_FAIL_VLD;
   logic [IDW-1:0]  FIRST_FAIL_IDX;
   logic            TIMEOUT;
   logic [31:0]     CYCLE_CNT;

   riscv_result_checker #(
      .NUM_TEST(NUM_TEST), .IDW(IDW), .TIMEOUT_CYC(TO_CYC)
   ) dut (
      .CLK(CLK), .RSTn(RSTn), .TBL_WE(TBL_WE), .TBL_IDX(TBL_IDX),
      .TBL_NUM_INST(TBL_NUM_INST), .TBL_ANS(TBL_ANS), .NUM_ENTRIES(NUM_ENTRIES),
      .START(START), .NUM_INST(NUM_INST), .OUTPUT_PORT(OUTPUT_PORT), .HALT(HALT),
      .BUSY(BUSY), .DONE(DONE), .ALL_PASS(ALL_PASS), .PASS_CNT(PASS_CNT),
      .FAIL_CNT(FAIL_CNT), .FIRST_FAIL_VLD(FIRST_FAIL_VLD),
      .FIRST_FAIL_IDX(FIRST_FAIL_IDX), .TIMEOUT(TIMEOUT), .CYCLE_CNT(CYCLE_CNT)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      int pass_cnt;
      int fail_cnt;
      int ff_vld;
      int ff_idx;
      int tmo;
      int all_pass;
      int cyc;
   } exp_t;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_fails  = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fails++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic load(input int idx, input int num, input int ans);
      TBL_WE       = 1'b1;
      TBL_IDX      = IDW'(idx);
      TBL_NUM_INST = 32'(num);
      TBL_ANS      = 32'(ans);
      tick();
      TBL_WE       = 1'b0;
   endtask

   task automatic start(input int n, input bit push, input exp_t e);
      NUM_INST    = '0;
      OUTPUT_PORT = '0;
      HALT        = 1'b0;
      NUM_ENTRIES = (IDW+1)'(n);
      START       = 1'b1;
      if (push) sb.push_back(e);
      tick();
      START       = 1'b0;
   endtask

   task automatic step(input int num, input int port, input bit halt);
      NUM_INST    = 32'(num);
      OUTPUT_PORT = 32'(port);
      HALT        = halt;
      tick();
      HALT        = 1'b0;
   endtask

   // Bounded wait for DONE, then compare DUT results with the oldest queued expectation.
   task automatic grade(input string name);
      exp_t e;
      for (int i = 0; i < 40 && !DONE; i++) tick();
      check({name, ".done"}, 32'(DONE), 32'd1);
      if (sb.size() == 0) begin
         check({name, ".sb_empty"}, 32'd0, 32'd1);
      end else begin
         e = sb.pop_front();
         check({name, ".pass_cnt"}, 32'(PASS_CNT), 32'(e.pass_cnt));
         check({name, ".fail_cnt"}, 32'(FAIL_CNT), 32'(e.fail_cnt));
         check({name, ".ff_vld"},   32'(FIRST_FAIL_VLD), 32'(e.ff_vld));
         if (e.ff_vld != 0) check({name, ".ff_idx"}, 32'(FIRST_FAIL_IDX), 32'(e.ff_idx));
         check({name, ".timeout"},  32'(TIMEOUT), 32'(e.tmo));
         check({name, ".all_pass"}, 32'(ALL_PASS), 32'(e.all_pass));
         check({name, ".cycle_cnt"}, CYCLE_CNT, 32'(e.cyc));
         check({name, ".busy"},     32'(BUSY), 32'd0);
      end
   endtask

   task automatic run_basic(input string name);
      start(3, 1'b1, '{3, 0, 0, 0, 0, 1, 3});
      step(1, 5, 1'b0);
      step(2, 0, 1'b0);
      step(3, 1, 1'b0);
      check({name, ".done_edge"}, 32'(DONE), 32'd1);
      grade(name);
   endtask

   initial begin
      exp_t none = '{0, 0, 0, 0, 0, 0, 0};

      tick();
      check("rst.busy", 32'(BUSY), 32'd0);
      check("rst.done", 32'(DONE), 32'd0);
      check("rst.all_pass", 32'(ALL_PASS), 32'd0);
      check("rst.counts", {PASS_CNT, FAIL_CNT, CYCLE_CNT[19:0]}, 32'd0);
      #2 RSTn = 1'b1;
      tick();

      load(0, 1, 5);
      load(1, 2, 0);
      load(2, 3, 1);

      run_basic("basic");

      start(3, 1'b1, '{2, 1, 1, 1, 0, 0, 3});
      check("fail.busy", 32'(BUSY), 32'd1);
      step(1, 5, 1'b0);
      step(2, 7, 1'b0);
      step(3, 1, 1'b0);
      grade("fail");

      start(3, 1'b1, '{2, 1, 1, 1, 0, 0, 3});
      step(1, 5, 1'b0);
      step(3, 1, 1'b0);
      check("skip.mid_busy", 32'(BUSY), 32'd1);
      step(3, 1, 1'b0);
      grade("skip");

      start(3, 1'b1, '{1, 2, 1, 1, 0, 0, 1});
      step(1, 5, 1'b1);
      check("halt.done_edge", 32'(DONE), 32'd1);
      grade("halt");

      start(3, 1'b1, '{0, 3, 1, 0, 1, 0, TO_CYC});
      for (int i = 0; i < TO_CYC - 1; i++) step(0, 0, 1'b0);
      check("tmo.busy_before", 32'(BUSY), 32'd1);
      step(0, 0, 1'b0);
      check("tmo.done_edge", 32'(DONE), 32'd1);
      grade("tmo");

      // Oversized entry count clamps to the table depth.
      start(31, 1'b1, '{1, NUM_TEST - 1, 1, 1, 0, 0, 1});
      step(1, 5, 1'b1);
      grade("clamp");

      start(0, 1'b1, '{0, 0, 0, 0, 0, 1, 0});
      check("empty.done_edge", 32'(DONE), 32'd1);
      grade("empty");

      // Table write while DONE must be dropped.
      load(0, 9, 9);

      start(3, 1'b0, none);
      step(1, 5, 1'b0);
      check("rstmid.pass_before", 32'(PASS_CNT), 32'd1);
      #2 RSTn = 1'b0;
      #1;
      check("rstmid.busy", 32'(BUSY), 32'd0);
      check("rstmid.done", 32'(DONE), 32'd0);
      check("rstmid.pass", 32'(PASS_CNT), 32'd0);
      check("rstmid.cycle", CYCLE_CNT, 32'd0);
      RSTn = 1'b1;
      tick();
      run_basic("rerun");

      check("sb.drained", 32'(sb.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
